// File: rtl/ssd1306_pkg.sv
// Shared types and word-format constants for the SSD1306 init sequencer.
package ssd1306_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } init_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DELAY = 3'd3,
    ST_DONE  = 3'd4
  } init_state_t;

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int ARG_MSB = 7;
  localparam int ARG_LSB = 0;

endpackage

// File: rtl/ssd1306_delay_timer.sv
// Down-counter for DELAY words: loads count*DELAY_UNIT-1 and runs to zero.
module ssd1306_delay_timer #(
  parameter int DELAY_UNIT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] count,
  input  logic       run,
  output logic       expired
);

  localparam int CNT_W = 8 + $clog2(DELAY_UNIT + 1);

  logic [CNT_W-1:0] cnt_p0;

  // Full-width product: 255*DELAY_UNIT always fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] delay_load(input logic [7:0] k);
    return CNT_W'(k) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= delay_load(count);
    end else if (run && (cnt_p0 != '0)) begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
    end
  end

  assign expired = (cnt_p0 == '0);

endmodule

// File: rtl/ssd1306_init_sequencer.sv
// Walks the init ROM from address 0 and streams CMD/DATA bytes to the
// display byte transmitter, honouring DELAY and END words.
module ssd1306_init_sequencer
  import ssd1306_pkg::*;
#(
  parameter  int ROM_SIZE     = 32,
  parameter  int DATA_WIDTH   = 10,
  parameter  int DELAY_UNIT   = 1000,
  localparam int ADDRESS_BITS = $clog2(ROM_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow_err,
  output logic [ADDRESS_BITS-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  input  logic                    rom_overflow,
  output logic                    tx_valid,
  output logic [7:0]              tx_byte,
  output logic                    tx_dc,
  input  logic                    tx_ready
);

  localparam bit ROM_POW2 = (ROM_SIZE == (1 << ADDRESS_BITS));

  init_state_t             state_q;
  logic [ADDRESS_BITS:0]   addr_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic                    ovf_q;

  init_op_t                fetch_op;
  logic [7:0]              fetch_arg;
  logic                    addr_ovf;
  logic                    timer_load;
  logic                    timer_run;
  logic                    timer_expired;

  assign fetch_op  = init_op_t'(rom_data[OP_MSB:OP_LSB]);
  assign fetch_arg = rom_data[ARG_MSB:ARG_LSB];

  // A power-of-two ROM cannot signal the one-past-end address itself,
  // so the extra counter bit stands in for it.
  assign addr_ovf   = rom_overflow || (ROM_POW2 && addr_q[ADDRESS_BITS]);
  assign timer_load = (state_q == ST_FETCH) && !addr_ovf &&
                      (fetch_op == OP_DELAY) && (fetch_arg != 8'd0);
  assign timer_run  = (state_q == ST_DELAY);

  ssd1306_delay_timer #(
    .DELAY_UNIT (DELAY_UNIT)
  ) u_delay_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .count   (fetch_arg),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (addr_ovf) begin
            ovf_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            word_q <= rom_data;
            addr_q <= addr_q + (ADDRESS_BITS + 1)'(1);
            case (fetch_op)
              OP_CMD, OP_DATA: state_q <= ST_SEND;
              OP_DELAY:        state_q <= (fetch_arg != 8'd0) ? ST_DELAY : ST_FETCH;
              default:         state_q <= ST_DONE;
            endcase
          end
        end
        ST_SEND: begin
          if (tx_ready) state_q <= ST_FETCH;
        end
        ST_DELAY: begin
          if (timer_expired) state_q <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_q == ST_FETCH) || (state_q == ST_SEND) || (state_q == ST_DELAY);
  assign done         = (state_q == ST_DONE);
  assign overflow_err = ovf_q;
  assign rom_address  = addr_q[ADDRESS_BITS-1:0];
  assign tx_valid     = (state_q == ST_SEND);
  assign tx_byte      = word_q[ARG_MSB:ARG_LSB];
  assign tx_dc        = (init_op_t'(word_q[OP_MSB:OP_LSB]) == OP_DATA);

endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// Scoreboard bench: a word-list model predicts bytes, timing gaps and end status.
module tb_ssd1306_init_sequencer;

  localparam int RS = 32;
  localparam int DU = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       overflow_err;
  logic [4:0] rom_address;
  logic [9:0] rom_data;
  logic       rom_overflow;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       tx_ready;

  logic [9:0] rom_img [RS];
  int         rom_len = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] b;
    bit         dc;
    bit         ovf;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   release_cyc = 0;
  int   rdy_mode = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data     = rom_img[rom_address];
  assign rom_overflow = (int'(rom_address) >= rom_len);

  ssd1306_init_sequencer #(
    .ROM_SIZE   (RS),
    .DATA_WIDTH (10),
    .DELAY_UNIT (DU)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .overflow_err (overflow_err),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .rom_overflow (rom_overflow),
    .tx_valid     (tx_valid),
    .tx_byte      (tx_byte),
    .tx_dc        (tx_dc),
    .tx_ready     (tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the word list, accumulating the cycles between
  // the moment the sequencer is free to fetch and the next visible event.
  function automatic void build_exp();
    int   acc = 1;
    exp_t e;
    for (int a = 0; a <= RS; a++) begin
      if (a >= rom_len) begin
        e = '{is_done: 1'b1, b: 8'h00, dc: 1'b0, ovf: 1'b1, gap: acc};
        exp_q.push_back(e);
        return;
      end
      case (rom_img[a][9:8])
        2'b00, 2'b01: begin
          e = '{is_done: 1'b0, b: rom_img[a][7:0], dc: rom_img[a][8], ovf: 1'b0, gap: acc};
          exp_q.push_back(e);
          acc = 1;
        end
        2'b10: acc += 1 + int'(rom_img[a][7:0]) * DU;
        default: begin
          e = '{is_done: 1'b1, b: 8'h00, dc: 1'b0, ovf: 1'b0, gap: acc};
          exp_q.push_back(e);
          return;
        end
      endcase
    end
  endfunction

  // Ready generator: 0 always ready, 1 random, 2 stall 0xA8 for 5 cycles, 3 never ready.
  initial begin
    int stall = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!tx_valid) stall = 0;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (tx_valid && tx_byte == 8'hA8 && stall < 5) begin
            tx_ready = 1'b0;
            stall++;
          end else begin
            tx_ready = 1'b1;
          end
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per new byte offer and per done rise.
  initial begin
    bit         in_offer  = 1'b0;
    bit         prev_done = 1'b0;
    logic [7:0] held_b    = 8'h00;
    logic       held_dc   = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_offer  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (tx_valid) begin
          check("valid_implies_busy", busy, 1'b1);
          if (!in_offer) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got %0h dc %0b expected none", tx_byte, tx_dc);
            end else begin
              e = exp_q.pop_front();
              check("kind_byte", 32'(e.is_done), 32'd0);
              check("tx_byte", tx_byte, e.b);
              check("tx_dc", tx_dc, e.dc);
              check("byte_gap", cyc - release_cyc, e.gap);
            end
            held_b   = tx_byte;
            held_dc  = tx_dc;
            in_offer = 1'b1;
          end else begin
            check("stall_byte_stable", tx_byte, held_b);
            check("stall_dc_stable", tx_dc, held_dc);
          end
          if (tx_ready) begin
            in_offer    = 1'b0;
            release_cyc = cyc + 1;
          end
        end
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            e = exp_q.pop_front();
            check("kind_done", 32'(e.is_done), 32'd1);
            check("overflow_err", overflow_err, e.ovf);
            check("done_gap", cyc - release_cyc, e.gap);
            check("busy_low_in_done", busy, 1'b0);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic load_img(input logic [9:0] w[$]);
    rom_len = w.size();
    for (int i = 0; i < RS; i++) rom_img[i] = (i < rom_len) ? w[i] : 10'h000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start       = 1'b1;
    release_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset_checks(input string tag);
    #1;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ovf"}, overflow_err, 1'b0);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_byte"}, tx_byte, 8'h00);
    check({tag, "_tx_dc"}, tx_dc, 1'b0);
    check({tag, "_rom_address"}, rom_address, 5'd0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    exp_q.delete();
    apply_reset_checks(tag);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic run_seq(input logic [9:0] w[$], input int mode, input int extra_start);
    int n = 0;
    rdy_mode = mode;
    load_img(w);
    build_exp();
    pulse_start();
    if (extra_start > 0) begin
      repeat (extra_start) @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got busy %0b expected done within 5000 cycles", busy);
      @(negedge clk);
      #2;
      do_reset("timeout_reset");
    end
    repeat (2) @(negedge clk);
    check("leftover_expectations", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [9:0] img[$];
    int n;
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] img[$];
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    load_img({10'h300});
    apply_reset_checks("reset");
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;

    img = {10'h0AE, 10'h08D, 10'h114, 10'h300};
    run_seq(img, 0, 0);
    img = {10'h203, 10'h0AF, 10'h300};
    run_seq(img, 0, 0);
    img = {10'h0A1, 10'h0A8, 10'h1A9, 10'h300};
    run_seq(img, 2, 0);

    img = {};
    for (int i = 0; i < RS; i++) img.push_back({2'b00, 8'(i + 8'h40)});
    run_seq(img, 0, 0);
    img = {10'h011, 10'h200, 10'h122, 10'h033};
    run_seq(img, 1, 0);

    img = {10'h0AE, 10'h08D, 10'h114, 10'h300};
    run_seq(img, 0, 3);
    run_seq(img, 0, 0);

    // Reset while a byte is held in SEND.
    img = {10'h0A8, 10'h0B1, 10'h300};
    rdy_mode = 3;
    load_img(img);
    build_exp();
    pulse_start();
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_send", tx_valid, 1'b1);
    #2;
    do_reset("send_reset");
    run_seq(img, 0, 0);

    // Reset during a long DELAY.
    img = {10'h0A1, 10'h2FF, 10'h0A2, 10'h300};
    rdy_mode = 0;
    load_img(img);
    build_exp();
    pulse_start();
    repeat (10) @(negedge clk);
    check("in_delay_busy", busy, 1'b1);
    check("in_delay_no_valid", tx_valid, 1'b0);
    #2;
    do_reset("delay_reset");
    run_seq(img, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int len = $urandom_range(1, RS);
      img = {};
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 19);
        if (r < 8)       img.push_back({2'b00, 8'($urandom)});
        else if (r < 14) img.push_back({2'b01, 8'($urandom)});
        else if (r < 18) img.push_back({2'b10, 8'($urandom_range(0, 3))});
        else if (r == 18 && (t % 3) == 0) img.push_back(10'h300);
        else             img.push_back({2'b00, 8'($urandom)});
      end
      run_seq(img, int'($urandom_range(0, 1)), (t % 4 == 1) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
